prog_loader: RTL
================

// Module: prog_loader
// PURPOSE
// - Serial boot loader upstream of the 8-bit CPU. Receives a framed program over a UART line,
//   writes it byte-by-byte into the 256x8 program/data RAM from address 0x00, then releases
//   the CPU to run.
// - Holds the CPU (cpu_hold) while loading. Reports success (load_done) or failure (load_err).
// PARAMETERS
// - CLKS_PER_BIT  16    clk cycles per UART bit; must be even and >= 4
// - SYNC_BYTE     8'hA5 frame start marker
// PORTS
// - clk        in   1  system clock, all logic on rising edge
// - rst        in   1  synchronous, active-high reset
// - rx         in   1  UART serial input; async, idle high
// - ram_we     out  1  RAM write strobe, one cycle per data byte
// - ram_addr   out  8  RAM write address
// - ram_wdata  out  8  RAM write data
// - cpu_hold   out  1  1 = CPU stalled/reset; 0 = CPU runs
// - load_done  out  1  1-cycle pulse when a frame's checksum passes
// - load_err   out  1  sticky error flag; cleared by rst or the next accepted SYNC_BYTE
// - state_dbg  out  3  current loader state encoding, for bench visibility
// BEHAVIOUR
// - Reset values: ram_we=0, ram_addr=0, ram_wdata=0, cpu_hold=1, load_done=0, load_err=0,
//   state=WAIT_SYNC, UART receiver idle. rst mid-frame aborts the frame immediately.
//
// - UART receiver (8N1, LSB first):
//   - rx passes a 2-flop synchroniser, reset to 1.
//   - Falling edge in idle starts a bit counter. At CLKS_PER_BIT/2 the start bit is re-checked;
//     if it is high, this is a glitch: drop it and return to idle.
//   - Each data bit is sampled every CLKS_PER_BIT after that.
//   - The stop bit is sampled likewise. Stop=1 produces a 1-cycle internal byte_vld with byte[7:0].
//     Stop=0 is a framing error and produces a 1-cycle frm_err instead.
//   - Receiver returns to idle right after the stop sample, so back-to-back frames are accepted.
//
// - Loader FSM (advances only on byte_vld or frm_err):
//   - WAIT_SYNC: byte==SYNC_BYTE -> GET_LEN, clear load_err, sum=0, addr=0.
//     Any other byte is ignored.
//   - GET_LEN: latch len = byte, where 0 means 256 -> GET_DATA.
//   - GET_DATA: cycle after byte_vld: ram_we=1, ram_wdata=byte, ram_addr=addr.
//     Then addr+=1 (8-bit wrap) and sum+=byte (mod 256).
//     After the len-th write -> GET_SUM.
//   - GET_SUM: byte==sum -> RUN, load_done pulse, cpu_hold falls on the same cycle.
//     byte!=sum -> load_err=1, -> WAIT_SYNC, cpu_hold stays 1.
//   - RUN: cpu_hold=0. byte==SYNC_BYTE -> cpu_hold=1 on the cycle byte_vld is seen,
//     clear load_err, -> GET_LEN. Other bytes are ignored.
//   - frm_err in any state other than RUN: load_err=1, -> WAIT_SYNC, frame discarded.
//     frm_err in RUN is ignored.
//
// - Rules and boundaries:
//   - Bytes already written before an error stay in RAM. The CPU is never released on a bad image.
//   - len=256 writes 0x00..0xFF; ram_addr wraps to 0x00 after the last write.
//   - ram_we never asserts outside GET_DATA. ram_addr/ram_wdata hold their last value otherwise.
//   - load_done and ram_we are never high in the same cycle.
// TESTING
// (bench uses CLKS_PER_BIT=4)
// 1. Frame A5,03,11,22,33,66 -> ram_we 3x at addr 0,1,2 with data 11,22,33;
//    load_done pulses once; cpu_hold 1->0; load_err=0.
// 2. Frame A5,02,10,20,31 (bad sum, expected 30) -> 2 writes; load_err=1; cpu_hold stays 1;
//    state=WAIT_SYNC; a following good frame clears load_err and releases the CPU.
// 3. Frame A5,00 + 256 bytes of value i, then checksum 80 -> 256 writes at 0x00..0xFF;
//    ram_addr ends at 0x00; load_done pulses.
// 4. 1-cycle low glitch on idle rx, and garbage byte 5A before A5 -> no byte accepted and
//    no writes from the glitch; 5A ignored; the frame then loads normally.
// 5. Stop bit forced 0 on the second data byte -> load_err=1 and WAIT_SYNC;
//    the same stop error while in RUN -> no effect.
// 6. rst asserted during GET_DATA -> next cycle all outputs equal reset values;
//    a new A5 frame loads from addr 0. Also: A5 received in RUN -> cpu_hold=1 immediately.

Source files
------------

// File: rtl/prog_loader.sv
// Serial boot loader: receives a framed program over 8N1 UART, writes it into
// program RAM from address 0x00, verifies a mod-256 checksum and then releases
// the CPU. Frame: SYNC_BYTE, LEN (0 = 256), LEN data bytes, SUM.
module prog_loader #(
    parameter int          CLKS_PER_BIT = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       ram_we,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_wdata,
    output logic       cpu_hold,
    output logic       load_done,
    output logic       load_err,
    output logic [2:0] state_dbg
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [2:0] {
        LD_WAIT_SYNC = 3'd0,
        LD_GET_LEN   = 3'd1,
        LD_GET_DATA  = 3'd2,
        LD_GET_SUM   = 3'd3,
        LD_RUN       = 3'd4
    } ld_state_t;

    // UART receiver state
    logic          rx_s1_q, rx_s2_q, rx_s3_q;
    rx_state_t     rx_state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          byte_vld_q;
    logic          frm_err_q;
    logic [7:0]    byte_q;

    // Loader state
    ld_state_t     state_q;
    logic [8:0]    len_rem_q;
    logic [7:0]    sum_q;
    logic          ram_we_q;
    logic [7:0]    ram_addr_q;
    logic [7:0]    ram_wdata_q;
    logic          cpu_hold_q;
    logic          load_done_q;
    logic          load_err_q;

    // Synchronise rx, find the start edge, sample mid-bit and emit one byte or framing error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            rx_state_q <= RX_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            byte_vld_q <= 1'b0;
            frm_err_q  <= 1'b0;
            byte_q     <= '0;
        end else begin
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_s3_q    <= rx_s2_q;
            byte_vld_q <= 1'b0;
            frm_err_q  <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    // A true falling edge is required, so a low line left by a bad stop bit does not retrigger
                    if (rx_s3_q && !rx_s2_q) begin
                        rx_state_q <= RX_START;
                        cnt_q      <= '0;
                    end
                end
                RX_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q     <= '0;
                        bit_cnt_q <= '0;
                        // Line back high at mid start bit means a glitch
                        rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s2_q, shift_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q      <= '0;
                        rx_state_q <= RX_IDLE;
                        if (rx_s2_q) begin
                            byte_vld_q <= 1'b1;
                            byte_q     <= shift_q;
                        end else begin
                            frm_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // Frame parser: length, RAM writes, checksum and CPU hold/release
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LD_WAIT_SYNC;
            len_rem_q   <= '0;
            sum_q       <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            // Address advances the cycle after each write, so it wraps to 0x00 after a 256-byte image
            if (ram_we_q) begin
                ram_we_q   <= 1'b0;
                ram_addr_q <= ram_addr_q + 1'b1;
            end
            if (frm_err_q && (state_q != LD_RUN)) begin
                load_err_q <= 1'b1;
                state_q    <= LD_WAIT_SYNC;
            end else if (byte_vld_q) begin
                case (state_q)
                    LD_WAIT_SYNC: begin
                        if (byte_q == SYNC_BYTE) begin
                            state_q    <= LD_GET_LEN;
                            load_err_q <= 1'b0;
                            sum_q      <= '0;
                            ram_addr_q <= '0;
                        end
                    end
                    LD_GET_LEN: begin
                        len_rem_q <= (byte_q == 8'h00) ? 9'd256 : {1'b0, byte_q};
                        state_q   <= LD_GET_DATA;
                    end
                    LD_GET_DATA: begin
                        ram_we_q    <= 1'b1;
                        ram_wdata_q <= byte_q;
                        sum_q       <= sum_q + byte_q;
                        len_rem_q   <= len_rem_q - 1'b1;
                        if (len_rem_q == 9'd1) begin
                            state_q <= LD_GET_SUM;
                        end
                    end
                    LD_GET_SUM: begin
                        if (byte_q == sum_q) begin
                            state_q     <= LD_RUN;
                            load_done_q <= 1'b1;
                            cpu_hold_q  <= 1'b0;
                        end else begin
                            load_err_q <= 1'b1;
                            state_q    <= LD_WAIT_SYNC;
                        end
                    end
                    LD_RUN: begin
                        if (byte_q == SYNC_BYTE) begin
                            cpu_hold_q <= 1'b1;
                            load_err_q <= 1'b0;
                            sum_q      <= '0;
                            ram_addr_q <= '0;
                            state_q    <= LD_GET_LEN;
                        end
                    end
                    default: state_q <= LD_WAIT_SYNC;
                endcase
            end
        end
    end

    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;
    assign state_dbg = state_q;

endmodule
